// File: rtl/zc_period_meter.sv
// Zero-crossing period meter: counts enabled samples between accepted crossings,
// rejects short glitches, flags loss of signal and keeps a 4-period running mean.
//
// state | meaning
// ARM   | waiting for the first crossing after reset/clear
// MEAS  | counting samples between crossings
// LOST  | no crossing within MAX_PERIOD, timeout asserted
module zc_period_meter #(
  parameter int CNT_W      = 24,
  parameter int MIN_PERIOD = 4,
  parameter int MAX_PERIOD = 2**CNT_W-1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             zc_flag,
  input  logic             clear,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic [CNT_W-1:0] period_avg,
  output logic             avg_valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W:0]   MIN_W = (CNT_W+1)'(MIN_PERIOD);

  typedef enum logic [1:0] {ARM, MEAS, LOST} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hist [4];
  logic [1:0]       wr_ptr;
  logic [2:0]       fill;
  logic [CNT_W+1:0] sum;

  logic [CNT_W:0]   p_raw;
  logic [CNT_W-1:0] p_sat;
  logic             accept;
  logic [CNT_W+1:0] sum_next;

  // A crossing exactly at the saturation point would give MAX_PERIOD+1; clamp it.
  always_comb begin
    p_raw    = {1'b0, cnt} + {{CNT_W{1'b0}}, enable};
    p_sat    = (p_raw > {1'b0, MAX_C}) ? MAX_C : p_raw[CNT_W-1:0];
    accept   = zc_flag && (p_raw >= MIN_W);
    sum_next = sum + {2'b00, p_sat} - {2'b00, hist[wr_ptr]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ARM;
      cnt          <= '0;
      wr_ptr       <= '0;
      fill         <= '0;
      sum          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      period_avg   <= '0;
      avg_valid    <= 1'b0;
      timeout      <= 1'b0;
      for (int i = 0; i < 4; i++) hist[i] <= '0;
    end else begin
      period_valid <= 1'b0;
      avg_valid    <= 1'b0;
      if (clear) begin
        state      <= ARM;
        cnt        <= '0;
        wr_ptr     <= '0;
        fill       <= '0;
        sum        <= '0;
        period     <= '0;
        period_avg <= '0;
        timeout    <= 1'b0;
        for (int i = 0; i < 4; i++) hist[i] <= '0;
      end else begin
        case (state)
          ARM: begin
            if (zc_flag) begin
              state <= MEAS;
              cnt   <= '0;
            end
          end
          MEAS: begin
            if (accept) begin
              period       <= p_sat;
              period_valid <= 1'b1;
              cnt          <= '0;
              hist[wr_ptr] <= p_sat;
              wr_ptr       <= wr_ptr + 2'd1;
              sum          <= sum_next;
              if (fill >= 3'd3) begin
                fill       <= 3'd4;
                avg_valid  <= 1'b1;
                period_avg <= sum_next[CNT_W+1:2];
              end else begin
                fill <= fill + 3'd1;
              end
            end else if (cnt == MAX_C) begin
              // Loss of signal: the averaging history restarts from empty.
              state   <= LOST;
              timeout <= 1'b1;
              wr_ptr  <= '0;
              fill    <= '0;
              sum     <= '0;
              for (int i = 0; i < 4; i++) hist[i] <= '0;
            end else begin
              cnt <= cnt + {{(CNT_W-1){1'b0}}, enable};
            end
          end
          LOST: begin
            if (zc_flag) begin
              state   <= MEAS;
              cnt     <= '0;
              timeout <= 1'b0;
            end
          end
          default: state <= ARM;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_zc_period_meter.sv
// Bench for zc_period_meter (CNT_W=8, MAX_PERIOD=255): directed scenarios plus random
// stimulus, all compared every cycle against a crossing-level reference model.
module tb_zc_period_meter;

  localparam int W    = 8;
  localparam int MINP = 4;
  localparam int MAXP = 255;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         zc_flag;
  logic         clear;
  logic [W-1:0] period;
  logic         period_valid;
  logic [W-1:0] period_avg;
  logic         avg_valid;
  logic         timeout;

  int checks = 0;
  int errors = 0;

  // reference model state: mode 0 = waiting, 1 = measuring, 2 = signal lost
  int           m_mode;
  int           m_samples;
  int           m_hist[$];
  logic [W-1:0] m_period;
  logic [W-1:0] m_avg;
  logic         m_pv;
  logic         m_av;
  logic         m_to;

  zc_period_meter #(.CNT_W(W), .MIN_PERIOD(MINP), .MAX_PERIOD(MAXP)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .zc_flag      (zc_flag),
    .clear        (clear),
    .period       (period),
    .period_valid (period_valid),
    .period_avg   (period_avg),
    .avg_valid    (avg_valid),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W+2:0] obs();
    return {period_valid, avg_valid, timeout, period, period_avg};
  endfunction

  function automatic logic [2*W+2:0] expv();
    return {m_pv, m_av, m_to, m_period, m_avg};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_samples = 0; m_hist.delete();
    m_period = '0; m_avg = '0; m_pv = 0; m_av = 0; m_to = 0;
  endtask

  task automatic model_step(input logic en, input logic zc, input logic clr);
    int p;
    int s;
    m_pv = 0;
    m_av = 0;
    if (clr) begin
      model_reset();
    end else if (m_mode == 0) begin
      if (zc) begin m_mode = 1; m_samples = 0; end
    end else if (m_mode == 1) begin
      p = m_samples + int'(en);
      if (zc && p >= MINP) begin
        if (p > MAXP) p = MAXP;
        m_period = W'(p);
        m_pv = 1;
        m_samples = 0;
        m_hist.push_back(p);
        if (m_hist.size() > 4) void'(m_hist.pop_front());
        if (m_hist.size() == 4) begin
          s = 0;
          foreach (m_hist[i]) s += m_hist[i];
          m_avg = W'(s / 4);
          m_av = 1;
        end
      end else if (m_samples >= MAXP) begin
        m_mode = 2;
        m_to = 1;
        m_hist.delete();
      end else begin
        m_samples += int'(en);
      end
    end else begin
      if (zc) begin m_mode = 1; m_samples = 0; m_to = 0; end
    end
  endtask

  task automatic tick(input logic en, input logic zc, input logic clr);
    enable = en; zc_flag = zc; clear = clr;
    @(posedge clk);
    #1;
    model_step(en, zc, clr);
    enable = 0; zc_flag = 0; clear = 0;
  endtask

  task automatic test_reset();
    reset = 0; enable = 0; zc_flag = 0; clear = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs() !== '0) begin
      errors++; $display("FAIL reset_outputs got %h exp 0", obs());
    end
    reset = 1;
    tick(0, 0, 0);
    checks++;
    if (obs() !== expv()) begin
      errors++; $display("FAIL reset_release got %h exp %h", obs(), expv());
    end
  endtask

  task automatic test_basic();
    int pv = 0, av = 0;
    tick(0, 0, 1);
    for (int c = 0; c <= 220; c++) begin
      tick(1, (c == 10 || c == 110 || c == 210), 0);
      pv += int'(period_valid); av += int'(avg_valid);
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL basic cyc %0d got %h exp %h", c, obs(), expv());
      end
    end
    checks++;
    if (period !== 8'd100 || pv != 2 || av != 0) begin
      errors++; $display("FAIL basic_summary got period %0d pv %0d av %0d exp 100 2 0", period, pv, av);
    end
  endtask

  task automatic test_sparse_enable();
    int av = 0;
    tick(0, 0, 1);
    for (int c = 0; c <= 800; c++) begin
      tick((c % 4) == 0, (c % 200) == 0, 0);
      av += int'(avg_valid);
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL sparse cyc %0d got %h exp %h", c, obs(), expv());
      end
    end
    checks++;
    if (period !== 8'd50 || period_avg !== 8'd50 || av != 1) begin
      errors++; $display("FAIL sparse_summary got %0d/%0d av %0d exp 50/50 1", period, period_avg, av);
    end
  endtask

  task automatic test_average();
    tick(0, 0, 1);
    for (int c = 0; c <= 500; c++) begin
      tick(1, (c == 0 || c == 100 || c == 200 || c == 300 || c == 404 || c == 500), 0);
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL average cyc %0d got %h exp %h", c, obs(), expv());
      end
      if (c == 404) begin
        checks++;
        if (period_avg !== 8'd101 || avg_valid !== 1'b1) begin
          errors++; $display("FAIL average_101 got %0d v %b exp 101 v 1", period_avg, avg_valid);
        end
      end
    end
    checks++;
    if (period_avg !== 8'd100) begin
      errors++; $display("FAIL average_100 got %0d exp 100", period_avg);
    end
  endtask

  task automatic test_glitch();
    int pv = 0;
    tick(0, 0, 1);
    for (int c = 0; c <= 100; c++) begin
      tick(1, (c == 0 || c == 2 || c == 100), 0);
      pv += int'(period_valid);
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL glitch cyc %0d got %h exp %h", c, obs(), expv());
      end
    end
    checks++;
    if (period !== 8'd100 || pv != 1) begin
      errors++; $display("FAIL glitch_summary got %0d pv %0d exp 100 1", period, pv);
    end
  endtask

  task automatic test_timeout();
    tick(0, 0, 1);
    for (int c = 0; c <= 320; c++) begin
      tick(1, (c == 0 || c == 270 || c == 320), 0);
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL timeout cyc %0d got %h exp %h", c, obs(), expv());
      end
      if (c == 255 || c == 256 || c == 270) begin
        checks++;
        if (timeout !== (c == 256) || period_valid !== 1'b0) begin
          errors++; $display("FAIL timeout_edge cyc %0d got to %b pv %b exp to %b pv 0", c, timeout, period_valid, c == 256);
        end
      end
    end
    checks++;
    if (period !== 8'd50 || timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_recover got %0d to %b exp 50 0", period, timeout);
    end
    // crossing on the very cycle the counter sits at MAX_PERIOD
    tick(0, 0, 1);
    for (int c = 0; c <= 256; c++) begin
      tick(1, (c == 0 || c == 256), 0);
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL maxedge cyc %0d got %h exp %h", c, obs(), expv());
      end
    end
    checks++;
    if (period !== 8'd255 || period_valid !== 1'b1 || timeout !== 1'b0) begin
      errors++; $display("FAIL maxedge_summary got %0d pv %b to %b exp 255 1 0", period, period_valid, timeout);
    end
  endtask

  task automatic test_clear_reset();
    tick(0, 0, 1);
    for (int c = 0; c <= 100; c++) begin
      tick(1, (c == 0 || c == 40 || c == 80), c == 80);
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL clear cyc %0d got %h exp %h", c, obs(), expv());
      end
    end
    checks++;
    if (obs() !== '0) begin
      errors++; $display("FAIL clear_zero got %h exp 0", obs());
    end
    for (int c = 0; c <= 60; c++) begin
      tick(1, (c == 0 || c == 40), 0);
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL prereset cyc %0d got %h exp %h", c, obs(), expv());
      end
    end
    reset = 0;
    #1;
    model_reset();
    checks++;
    if (obs() !== '0) begin
      errors++; $display("FAIL async_reset got %h exp 0", obs());
    end
    #2;
    reset = 1;
    for (int c = 0; c <= 30; c++) begin
      tick(1, (c == 0), 0);
      checks++;
      if (obs() !== expv() || period_valid !== 1'b0) begin
        errors++; $display("FAIL postreset cyc %0d got %h exp %h", c, obs(), expv());
      end
    end
  endtask

  task automatic test_random();
    int zdiv;
    logic en, zc, clr;
    tick(0, 0, 1);
    for (int c = 0; c < 5000; c++) begin
      zdiv = ((c / 1000) % 2 == 1) ? 700 : 30;
      en  = ((c / 500) % 3 == 2) ? 1'b1 : 1'($urandom_range(0, 1));
      zc  = ($urandom_range(0, zdiv - 1) == 0);
      clr = ($urandom_range(0, 799) == 0);
      tick(en, zc, clr);
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL random cyc %0d got %h exp %h", c, obs(), expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sparse_enable();
    test_average();
    test_glitch();
    test_timeout();
    test_clear_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/zc_period_meter.md
ZC_PERIOD_METER -- requirements
Module: zc_period_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 24: width of the period counter and period outputs.
REQ-002 SHALL have parameter MIN_PERIOD, default 4: shortest accepted period in enabled samples; shorter crossings are treated as noise.
REQ-003 SHALL have parameter MAX_PERIOD, default 2**CNT_W-1: longest accepted period; reaching it without a crossing is loss of signal.
REQ-004 SHALL have port clk, input, 1: single clock; all logic is rising-edge.
REQ-005 SHALL have port reset, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port enable, input, 1: sample strobe, the same strobe driving the upstream zero-crossing detector.
REQ-007 SHALL have port zc_flag, input, 1: one-cycle pulse from the upstream zero-crossing detector (negative-going crossing).
REQ-008 SHALL have port clear, input, 1: synchronous restart to ARM.
REQ-009 SHALL have port period, output, CNT_W: last accepted period, in enabled samples.
REQ-010 SHALL have port period_valid, output, 1: one-cycle pulse when period updates.
REQ-011 SHALL have port period_avg, output, CNT_W: mean of the last 4 accepted periods, truncated.
REQ-012 SHALL have port avg_valid, output, 1: one-cycle pulse when period_avg updates.
REQ-013 SHALL have port timeout, output, 1: level, high while in LOST.

Function
REQ-014 SHALL implement states ARM, MEAS and LOST; reset and clear enter ARM.
- ARM: wait for the first crossing.
- MEAS: count samples between crossings.
- LOST: no crossing within MAX_PERIOD.
REQ-015 SHALL, in ARM, on zc_flag=1: go to MEAS with cnt <= 0, emit no period_valid, leave period unchanged.
REQ-016 SHALL, in MEAS, increment cnt by 1 on every cycle with enable=1 and no zc_flag.
REQ-017 SHALL, in MEAS, on zc_flag=1, form candidate p = cnt + enable, where enable is taken as 0 or 1.
REQ-018 SHALL, if p >= MIN_PERIOD, register period <= p, pulse period_valid the next cycle, set cnt <= 0, and push p into the 4-entry average buffer.
REQ-019 SHALL, if p < MIN_PERIOD, ignore the flag: no output, cnt keeps counting as if no flag occurred.
REQ-020 SHALL, in MEAS, when cnt reaches MAX_PERIOD with no zc_flag in that cycle, enter LOST on the next clock.
- LOST entry: timeout <= 1, average buffer and fill count cleared, cnt held at MAX_PERIOD (saturates, never wraps), period retained.
REQ-021 SHALL give zc_flag priority over timeout when both occur in the same cycle; the period equals MAX_PERIOD and is accepted.
REQ-022 SHALL, in LOST, on zc_flag=1: go to MEAS with cnt <= 0 and timeout <= 0, emit no period_valid.
REQ-023 SHALL keep a running sum of CNT_W+2 bits over the last 4 accepted periods.
- On each push: sum <= sum + new - oldest.
- period_avg = sum >> 2.
REQ-024 SHALL pulse avg_valid in the same cycle as period_valid, only once the fill count reaches 4 since the last ARM or LOST; the first 3 accepted periods produce no avg_valid.
REQ-025 SHALL latch period and period_avg output registers on their valid pulses; valid pulses last exactly one cycle.
REQ-026 SHALL give clear priority over every other event, including zc_flag in the same cycle.
- Clear actions: state <= ARM, cnt, sum, buffer, fill count, period, period_avg, valid pulses and timeout all go to 0.
REQ-027 SHALL give each output a latency of exactly 1 clock from the zc_flag cycle that causes it.

Reset
REQ-028 SHALL, while reset=0, asynchronously force state ARM and all outputs, counters, buffer and sum to 0.
REQ-029 SHALL resume operation on the first rising clk edge after reset rises; reset asserted mid-measurement discards the partial count.

Verification
REQ-030 SHALL cover: enable=1 constant, zc_flag pulses at cycles 10, 110, 210 -> period_valid at cycles 111 and 211, period=100, no avg_valid.
REQ-031 SHALL cover: enable high 1 cycle in 4, crossings 200 clocks apart -> period=50 each time; avg_valid first on the 4th accepted period with period_avg=50.
REQ-032 SHALL cover: accepted periods 100, 100, 100, 104 -> period_avg=101 with avg_valid; a next period of 96 -> period_avg=100.
REQ-033 SHALL cover: in MEAS, a second zc_flag 2 samples after the first (MIN_PERIOD=4), then the true crossing 100 samples after the first -> no pulse for the glitch, period=100.
REQ-034 SHALL cover: CNT_W=8, MAX_PERIOD=255, no crossing -> timeout=1 the cycle after cnt hits 255; next zc_flag -> timeout=0, no period_valid; the following crossing is measured normally.
REQ-035 SHALL cover: clear and zc_flag in the same cycle mid-MEAS, then reset pulsed low mid-MEAS -> ARM each time, all outputs 0, no period_valid.
